// File: rtl/hsk_cobs_pkg.sv
// Shared constants, FSM state type and code-byte helper for the housekeeping COBS encoder.
package hsk_cobs_pkg;

   localparam logic [7:0] COBS_DELIM    = 8'h00;
   localparam logic [7:0] COBS_MAX_CODE = 8'hFF;

   typedef enum logic [2:0] {
      FILL,
      CODE,
      DATA,
      END_CHK,
      DELIM
   } cobs_state_t;

   // A block of n data bytes is announced by the code byte n+1.
   function automatic logic [7:0] cobs_code(input logic [7:0] n);
      return n + 8'd1;
   endfunction

endpackage

// File: rtl/hsk_cobs_blockbuf.sv
// Block buffer for one COBS block: distributed RAM, synchronous write, asynchronous read.
module hsk_cobs_blockbuf #(
   parameter int DEPTH = 254
) (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] waddr,
   input  logic [7:0] wdata,
   input  logic [7:0] raddr,
   output logic [7:0] rdata
);

   logic [7:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/hsk_cobs_encode.sv
// AXI4-Stream COBS encoder: buffers one block, emits code + data bytes, then a 0x00 delimiter with tlast.
// Optional statistics outputs (pkt_count, max_len) are enabled by defining HSK_COBS_ENCODE_STATS_EN.
module hsk_cobs_encode
   import hsk_cobs_pkg::*;
#(
   parameter int MAX_CODE = int'(COBS_MAX_CODE)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       busy
`ifdef HSK_COBS_ENCODE_STATS_EN
   ,
   output logic [15:0] pkt_count,
   output logic [7:0]  max_len
`endif
);

   localparam int         DEPTH = MAX_CODE - 1;
   localparam logic [7:0] FULL  = 8'(MAX_CODE - 1);

   cobs_state_t state_reg, state_next;
   logic [7:0]  count_reg, count_next;
   logic [7:0]  rd_ptr_reg, rd_ptr_next;
   logic        last_pend_reg, last_pend_next;
   logic        trail_pend_reg, trail_pend_next;
   logic        busy_reg, busy_next;
   logic        tready_reg, tready_next;
   logic        tvalid_reg, tvalid_next;
   logic [7:0]  tdata_reg, tdata_next;
   logic        tlast_reg, tlast_next;
   logic        buf_we;
   logic [7:0]  buf_rdata;
   logic        in_fire;
   logic        out_fire;

   assign in_fire  = s_axis_tvalid & tready_reg;
   assign out_fire = tvalid_reg & m_axis_tready;

   // Read address follows the next pointer so the registered output already holds the byte.
   hsk_cobs_blockbuf #(
      .DEPTH (DEPTH)
   ) u_blockbuf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (count_reg),
      .wdata (s_axis_tdata),
      .raddr (rd_ptr_next),
      .rdata (buf_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= FILL;
         count_reg      <= 8'd0;
         rd_ptr_reg     <= 8'd0;
         last_pend_reg  <= 1'b0;
         trail_pend_reg <= 1'b0;
         busy_reg       <= 1'b0;
         tready_reg     <= 1'b0;
         tvalid_reg     <= 1'b0;
         tdata_reg      <= 8'h00;
         tlast_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         rd_ptr_reg     <= rd_ptr_next;
         last_pend_reg  <= last_pend_next;
         trail_pend_reg <= trail_pend_next;
         busy_reg       <= busy_next;
         tready_reg     <= tready_next;
         tvalid_reg     <= tvalid_next;
         tdata_reg      <= tdata_next;
         tlast_reg      <= tlast_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      count_next      = count_reg;
      rd_ptr_next     = rd_ptr_reg;
      last_pend_next  = last_pend_reg;
      trail_pend_next = trail_pend_reg;
      busy_next       = busy_reg;
      buf_we          = 1'b0;
      case (state_reg)
         FILL: begin
            if (in_fire) begin
               busy_next = 1'b1;
               if (s_axis_tdata == COBS_DELIM) begin
                  state_next      = CODE;
                  last_pend_next  = s_axis_tlast;
                  trail_pend_next = s_axis_tlast;
               end else begin
                  buf_we     = 1'b1;
                  count_next = count_reg + 8'd1;
                  // A full block carries no implied zero, so it never needs a trailing 0x01.
                  if ((count_next == FULL) || s_axis_tlast) begin
                     state_next      = CODE;
                     last_pend_next  = s_axis_tlast;
                     trail_pend_next = 1'b0;
                  end
               end
            end
         end
         CODE: begin
            if (out_fire) begin
               rd_ptr_next = 8'd0;
               state_next  = (count_reg != 8'd0) ? DATA : END_CHK;
            end
         end
         DATA: begin
            if (out_fire) begin
               if (rd_ptr_reg == count_reg - 8'd1) begin
                  rd_ptr_next = 8'd0;
                  state_next  = END_CHK;
               end else begin
                  rd_ptr_next = rd_ptr_reg + 8'd1;
               end
            end
         end
         END_CHK: begin
            if (!last_pend_reg) begin
               count_next = 8'd0;
               state_next = FILL;
            end else if (trail_pend_reg) begin
               count_next      = 8'd0;
               trail_pend_next = 1'b0;
               state_next      = CODE;
            end else begin
               state_next = DELIM;
            end
         end
         DELIM: begin
            if (out_fire) begin
               count_next      = 8'd0;
               last_pend_next  = 1'b0;
               trail_pend_next = 1'b0;
               busy_next       = 1'b0;
               state_next      = FILL;
            end
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   always_comb begin
      tready_next = (state_next == FILL);
      tvalid_next = 1'b0;
      tdata_next  = 8'h00;
      tlast_next  = 1'b0;
      case (state_next)
         CODE: begin
            tvalid_next = 1'b1;
            tdata_next  = cobs_code(count_next);
         end
         DATA: begin
            tvalid_next = 1'b1;
            tdata_next  = buf_rdata;
         end
         DELIM: begin
            tvalid_next = 1'b1;
            tdata_next  = COBS_DELIM;
            tlast_next  = 1'b1;
         end
         default: begin
            tvalid_next = 1'b0;
         end
      endcase
   end

   assign s_axis_tready = tready_reg;
   assign m_axis_tvalid = tvalid_reg;
   assign m_axis_tdata  = tdata_reg;
   assign m_axis_tlast  = tlast_reg;
   assign busy          = busy_reg;

`ifdef HSK_COBS_ENCODE_STATS_EN
   logic [15:0] pkt_count_reg;
   logic [7:0]  max_len_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count_reg <= 16'd0;
         max_len_reg   <= 8'd0;
      end else begin
         if ((state_reg == DELIM) && out_fire) begin
            pkt_count_reg <= pkt_count_reg + 16'd1;
         end
         if ((state_reg == CODE) && out_fire && (tdata_reg > max_len_reg)) begin
            max_len_reg <= tdata_reg;
         end
      end
   end

   assign pkt_count = pkt_count_reg;
   assign max_len   = max_len_reg;
`endif

endmodule

// File: tb/tb_hsk_cobs_encode.sv
// Scoreboard bench for hsk_cobs_encode: directed packets push expected encoded bytes, a monitor pops and compares.
module tb_hsk_cobs_encode;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] s_axis_tdata = 8'h00;
   logic       s_axis_tvalid = 1'b0;
   logic       s_axis_tready;
   logic       s_axis_tlast = 1'b0;
   logic [7:0] m_axis_tdata;
   logic       m_axis_tvalid;
   logic       m_axis_tready = 1'b1;
   logic       m_axis_tlast;
   logic       busy;
`ifdef HSK_COBS_ENCODE_STATS_EN
   logic [15:0] pkt_count;
   logic [7:0]  max_len;
`endif

   int checks = 0;
   int errors = 0;
   int out_idx = 0;
   int ready_mode = 0;   // 0: hold high, 1: toggle each cycle, 2: driven by main sequence
   bit mon_en = 1'b0;
   logic [8:0] exp_q [$];

   always #5 clk = ~clk;

   hsk_cobs_encode dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .busy          (busy)
`ifdef HSK_COBS_ENCODE_STATS_EN
      ,
      .pkt_count     (pkt_count),
      .max_len       (max_len)
`endif
   );

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 0) m_axis_tready = 1'b1;
         else if (ready_mode == 1) m_axis_tready = ~m_axis_tready;
      end
   end

   // Monitor: pops the scoreboard on every output handshake and checks stall stability.
   bit         stall_prev = 1'b0;
   logic [7:0] held_data;
   logic       held_last;
   always @(negedge clk) begin
      if (!rst_n || !mon_en) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            checks++;
            if (!m_axis_tvalid || m_axis_tdata !== held_data || m_axis_tlast !== held_last) begin
               errors++;
               $display("FAIL stall_hold: got valid=%0b data=%02h last=%0b, required valid=1 data=%02h last=%0b",
                        m_axis_tvalid, m_axis_tdata, m_axis_tlast, held_data, held_last);
            end
         end
         if (m_axis_tvalid) begin
            checks++;
            if (s_axis_tready !== 1'b0) begin
               errors++;
               $display("FAIL ready_outside_fill: got s_axis_tready=%0b, required 0", s_axis_tready);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out: got data=%02h last=%0b, required no output", m_axis_tdata, m_axis_tlast);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               $display("OUT %0d data=%02h last=%0b", out_idx, m_axis_tdata, m_axis_tlast);
               if (m_axis_tdata !== e[7:0] || m_axis_tlast !== e[8]) begin
                  errors++;
                  $display("FAIL out_byte_%0d: got data=%02h last=%0b, required data=%02h last=%0b",
                           out_idx, m_axis_tdata, m_axis_tlast, e[7:0], e[8]);
               end
            end
            out_idx++;
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         held_data  = m_axis_tdata;
         held_last  = m_axis_tlast;
      end
   end

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic push(input logic [7:0] b);
      exp_q.push_back({1'b0, b});
   endtask

   task automatic push_delim();
      exp_q.push_back({1'b1, 8'h00});
   endtask

   // Drive one byte, starting at posedge+1; returns at posedge+1 after its handshake.
   task automatic send_byte(input logic [7:0] b, input logic l);
      int  t;
      bit  done;
      t = 0;
      done = 1'b0;
      s_axis_tdata  = b;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      while (!done) begin
         @(negedge clk);
         if (s_axis_tready) begin
            done = 1'b1;
         end else begin
            t++;
            if (t > 2000) begin
               errors++;
               $display("FAIL send_timeout: got no s_axis_tready for byte %02h, required handshake", b);
               done = 1'b1;
            end
         end
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d bytes outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      @(posedge clk);
      #1;
      check({name, "_busy_low"}, 16'(busy), 16'd0);
      check({name, "_idle_valid"}, 16'(m_axis_tvalid), 16'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst_s_tready", 16'(s_axis_tready), 16'd0);
      check("rst_m_tvalid", 16'(m_axis_tvalid), 16'd0);
      check("rst_m_tdata", 16'(m_axis_tdata), 16'd0);
      check("rst_m_tlast", 16'(m_axis_tlast), 16'd0);
      check("rst_busy", 16'(busy), 16'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_s_tready", 16'(s_axis_tready), 16'd1);
      mon_en = 1'b1;

      // 11 22 00 33(last) -> 03 11 22 02 33 00
      push(8'h03); push(8'h11); push(8'h22); push(8'h02); push(8'h33); push_delim();
      send_byte(8'h11, 1'b0);
      check("busy_after_first", 16'(busy), 16'd1);
      send_byte(8'h22, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h33, 1'b1);
      wait_drain("basic");

      // Single 00(last) -> 01 01 00
      push(8'h01); push(8'h01); push_delim();
      send_byte(8'h00, 1'b1);
      wait_drain("single_zero");

      // 254 bytes 01..FE, last on FE -> FF 01..FE 00, no trailing 01
      push(8'hFF);
      for (int i = 1; i <= 254; i++) push(8'(i));
      push_delim();
      for (int i = 1; i <= 254; i++) send_byte(8'(i), i == 254);
      wait_drain("full_block");

      // 255 bytes 01..FF, last on FF -> FF 01..FE 02 FF 00
      push(8'hFF);
      for (int i = 1; i <= 254; i++) push(8'(i));
      push(8'h02); push(8'hFF); push_delim();
      for (int i = 1; i <= 255; i++) send_byte(8'(i), i == 255);
      wait_drain("overflow_block");

      // AA 00 00 BB(last) with toggling ready -> 02 AA 01 02 BB 00
      ready_mode = 1;
      push(8'h02); push(8'hAA); push(8'h01); push(8'h02); push(8'hBB); push_delim();
      send_byte(8'hAA, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'h00, 1'b0);
      send_byte(8'hBB, 1'b1);
      wait_drain("toggle_ready");

      // Reset while presenting data bytes; partial packet is discarded
      mon_en = 1'b0;
      ready_mode = 2;
      m_axis_tready = 1'b0;
      send_byte(8'h10, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h30, 1'b0);
      send_byte(8'h00, 1'b0);
      check("pre_rst_code", 16'(m_axis_tdata), 16'h04);
      m_axis_tready = 1'b1;
      @(posedge clk);
      #1;
      m_axis_tready = 1'b0;
      check("pre_rst_data", 16'(m_axis_tdata), 16'h10);
      check("pre_rst_valid", 16'(m_axis_tvalid), 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_m_tvalid", 16'(m_axis_tvalid), 16'd0);
      check("async_rst_m_tdata", 16'(m_axis_tdata), 16'd0);
      check("async_rst_s_tready", 16'(s_axis_tready), 16'd0);
      check("async_rst_busy", 16'(busy), 16'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      ready_mode = 0;
      m_axis_tready = 1'b1;
      @(posedge clk);
      #1;
      check("rerst_s_tready", 16'(s_axis_tready), 16'd1);
      mon_en = 1'b1;
      push(8'h02); push(8'h55); push_delim();
      send_byte(8'h55, 1'b1);
      wait_drain("after_reset");
`ifdef HSK_COBS_ENCODE_STATS_EN
      check("stats_pkt_count", pkt_count, 16'd1);
      check("stats_max_len", 16'(max_len), 16'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
